// File: rtl/usb_ep_status_bus_if.sv
// Single-beat CSR bus between the CPU-side decoder and the EP status front end.
interface usb_ep_status_bus_if;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  op;
    logic        req;
    logic        ack;
    logic [15:0] rdata;

    modport master (output addr, wdata, op, req, input ack, rdata);
    modport slave  (input addr, wdata, op, req, output ack, rdata);
endinterface

// File: rtl/usb_ep_status_bus.sv
// CSR bus to EP status store aux port: read, write, and read-modify-write bit set/clear.
module usb_ep_status_bus #(
    parameter int READ_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    usb_ep_status_bus_if.slave    bus,
    output logic [8:0]            s_addr_0,
    output logic                  s_read_0,
    output logic                  s_write_0,
    output logic [15:0]           s_din_0,
    input  logic [15:0]           s_dout_3,
    input  logic                  s_ready_0
);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] WB   = 3'd4;
    localparam logic [2:0] ACK  = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic [15:0]   mask_q;
    logic [15:0]   data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_RD;
            mask_q    <= '0;
            data_q    <= '0;
            s_addr_0  <= '0;
            s_read_0  <= 1'b0;
            s_write_0 <= 1'b0;
            s_din_0   <= '0;
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ack <= 1'b0;
            case (state)
                IDLE: begin
                    // A request still held during the ack cycle belongs to the finished transaction.
                    if (bus.req && !bus.ack) begin
                        op_q     <= bus.op;
                        mask_q   <= bus.wdata;
                        s_addr_0 <= bus.addr;
                        if (bus.op == OP_WR) begin
                            s_write_0 <= 1'b1;
                            s_din_0   <= bus.wdata;
                            state     <= WR;
                        end else begin
                            s_read_0 <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                WR, WB: begin
                    if (s_ready_0) begin
                        s_write_0 <= 1'b0;
                        state     <= ACK;
                    end
                end
                RD: begin
                    if (s_ready_0) begin
                        s_read_0 <= 1'b0;
                        cnt      <= CW'(READ_LAT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        data_q <= s_dout_3;
                        case (op_q)
                            OP_SET: begin
                                s_din_0   <= s_dout_3 | mask_q;
                                s_write_0 <= 1'b1;
                                state     <= WB;
                            end
                            OP_CLR: begin
                                s_din_0   <= s_dout_3 & ~mask_q;
                                s_write_0 <= 1'b1;
                                state     <= WB;
                            end
                            default: state <= ACK;
                        endcase
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    bus.ack <= 1'b1;
                    if (op_q != OP_WR) bus.rdata <= data_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_ep_status_bus.sv
// Directed bench for usb_ep_status_bus with a 3-cycle-latency status store model.
module tb_usb_ep_status_bus;
    logic        clk;
    logic        rst;
    logic [8:0]  s_addr_0;
    logic        s_read_0;
    logic        s_write_0;
    logic [15:0] s_din_0;
    logic [15:0] s_dout_3;
    logic        s_ready_0;

    int checks = 0;
    int failures = 0;

    usb_ep_status_bus_if bus_if ();

    usb_ep_status_bus #(.READ_LAT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .s_addr_0  (s_addr_0),
        .s_read_0  (s_read_0),
        .s_write_0 (s_write_0),
        .s_din_0   (s_din_0),
        .s_dout_3  (s_dout_3),
        .s_ready_0 (s_ready_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status store: data appears on s_dout_3 only in the cycle after the third edge.
    logic [15:0] mem [512];
    logic [15:0] p1, p2;
    int          n_rd = 0, n_wr = 0, n_ack = 0;
    logic [8:0]  last_waddr = '0;
    logic [15:0] last_wdin = '0;

    always @(posedge clk) begin
        if (s_read_0 && s_ready_0) begin
            p1   <= mem[s_addr_0];
            n_rd <= n_rd + 1;
        end else begin
            p1 <= 16'hDEAD;
        end
        p2       <= p1;
        s_dout_3 <= p2;
        if (s_write_0 && s_ready_0) begin
            mem[s_addr_0] <= s_din_0;
            n_wr          <= n_wr + 1;
            last_waddr    <= s_addr_0;
            last_wdin     <= s_din_0;
        end
        if (bus_if.ack) n_ack <= n_ack + 1;
    end

    task automatic do_txn(input logic [1:0] op, input logic [8:0] addr, input logic [15:0] wd,
                          input int stall, output int edges, output logic [15:0] rdata,
                          output int rd_hi, output bit addr_ok);
        int n;
        bus_if.op    = op;
        bus_if.addr  = addr;
        bus_if.wdata = wd;
        bus_if.req   = 1'b1;
        s_ready_0    = (stall < 1);
        rd_hi   = 0;
        addr_ok = 1'b1;
        edges   = -1;
        rdata   = 16'h0000;
        @(posedge clk); #1;
        if (s_read_0) begin rd_hi++; if (s_addr_0 !== addr) addr_ok = 1'b0; end
        n = 0;
        while (n < 60) begin
            s_ready_0 = (n + 1 > stall);
            @(posedge clk); #1;
            n++;
            if (s_read_0) begin rd_hi++; if (s_addr_0 !== addr) addr_ok = 1'b0; end
            if (bus_if.ack) begin
                edges = n;
                rdata = bus_if.rdata;
                break;
            end
        end
        bus_if.req = 1'b0;
        s_ready_0  = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_if.ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus_if.ack); end
        checks++; if (bus_if.rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", bus_if.rdata); end
        checks++; if (s_read_0 !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", s_read_0); end
        checks++; if (s_write_0 !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", s_write_0); end
        checks++; if (s_addr_0 !== 9'h0) begin failures++; $display("FAIL reset_addr got=%h exp=000", s_addr_0); end
        checks++; if (s_din_0 !== 16'h0) begin failures++; $display("FAIL reset_din got=%h exp=0000", s_din_0); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        int e, rh, w0, r0;
        logic [15:0] rd;
        bit ok;
        w0 = n_wr;
        do_txn(2'b01, 9'h012, 16'hA5C3, 0, e, rd, rh, ok);
        checks++; if (e !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", e); end
        checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL wr_rdata_unchanged got=%h exp=0000", rd); end
        checks++; if (n_wr - w0 !== 1) begin failures++; $display("FAIL wr_count got=%0d exp=1", n_wr - w0); end
        checks++; if (last_waddr !== 9'h012) begin failures++; $display("FAIL wr_addr got=%h exp=012", last_waddr); end
        checks++; if (last_wdin !== 16'hA5C3) begin failures++; $display("FAIL wr_din got=%h exp=a5c3", last_wdin); end
        r0 = n_rd;
        do_txn(2'b00, 9'h012, 16'h0000, 0, e, rd, rh, ok);
        checks++; if (e !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", e); end
        checks++; if (rd !== 16'hA5C3) begin failures++; $display("FAIL rd_data got=%h exp=a5c3", rd); end
        checks++; if (n_rd - r0 !== 1) begin failures++; $display("FAIL rd_count got=%0d exp=1", n_rd - r0); end
    endtask

    task automatic test_stall;
        int e, rh, r0;
        logic [15:0] rd;
        bit ok;
        r0 = n_rd;
        do_txn(2'b00, 9'h012, 16'h0000, 4, e, rd, rh, ok);
        checks++; if (e !== 9) begin failures++; $display("FAIL stall_latency got=%0d exp=9", e); end
        checks++; if (rh !== 5) begin failures++; $display("FAIL stall_read_held got=%0d exp=5", rh); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stall_addr_stable got=%b exp=1", ok); end
        checks++; if (n_rd - r0 !== 1) begin failures++; $display("FAIL stall_rd_count got=%0d exp=1", n_rd - r0); end
        checks++; if (rd !== 16'hA5C3) begin failures++; $display("FAIL stall_data got=%h exp=a5c3", rd); end
    endtask

    task automatic test_set;
        int e, rh, r0;
        logic [15:0] rd;
        bit ok;
        do_txn(2'b01, 9'h040, 16'h00F0, 0, e, rd, rh, ok);
        r0 = n_rd;
        do_txn(2'b10, 9'h040, 16'h0103, 0, e, rd, rh, ok);
        checks++; if (e !== 6) begin failures++; $display("FAIL set_latency got=%0d exp=6", e); end
        checks++; if (rd !== 16'h00F0) begin failures++; $display("FAIL set_rdata got=%h exp=00f0", rd); end
        checks++; if (last_wdin !== 16'h01F3) begin failures++; $display("FAIL set_wb_din got=%h exp=01f3", last_wdin); end
        checks++; if (last_waddr !== 9'h040) begin failures++; $display("FAIL set_wb_addr got=%h exp=040", last_waddr); end
        checks++; if (n_rd - r0 !== 1) begin failures++; $display("FAIL set_rd_count got=%0d exp=1", n_rd - r0); end
        do_txn(2'b00, 9'h040, 16'h0000, 0, e, rd, rh, ok);
        checks++; if (rd !== 16'h01F3) begin failures++; $display("FAIL set_readback got=%h exp=01f3", rd); end
    endtask

    task automatic test_clear;
        int e, rh;
        logic [15:0] rd;
        bit ok;
        do_txn(2'b01, 9'h1FF, 16'hFFFF, 0, e, rd, rh, ok);
        do_txn(2'b11, 9'h1FF, 16'h8001, 0, e, rd, rh, ok);
        checks++; if (e !== 6) begin failures++; $display("FAIL clr_latency got=%0d exp=6", e); end
        checks++; if (rd !== 16'hFFFF) begin failures++; $display("FAIL clr_rdata got=%h exp=ffff", rd); end
        checks++; if (last_wdin !== 16'h7FFE) begin failures++; $display("FAIL clr_wb_din got=%h exp=7ffe", last_wdin); end
        do_txn(2'b00, 9'h1FF, 16'h0000, 0, e, rd, rh, ok);
        checks++; if (rd !== 16'h7FFE) begin failures++; $display("FAIL clr_readback got=%h exp=7ffe", rd); end
    endtask

    task automatic test_back_to_back;
        int n, first, second, a0, r0;
        a0 = n_ack;
        r0 = n_rd;
        first  = -1;
        second = -1;
        bus_if.op   = 2'b00;
        bus_if.addr = 9'h012;
        bus_if.req  = 1'b1;
        s_ready_0   = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (n < 40 && second < 0) begin
            @(posedge clk); #1;
            n++;
            if (bus_if.ack) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        bus_if.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (first !== 5) begin failures++; $display("FAIL b2b_first_ack got=%0d exp=5", first); end
        checks++; if (second !== 12) begin failures++; $display("FAIL b2b_second_ack got=%0d exp=12", second); end
        checks++; if (n_ack - a0 !== 2) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=2", n_ack - a0); end
        checks++; if (n_rd - r0 !== 2) begin failures++; $display("FAIL b2b_rd_count got=%0d exp=2", n_rd - r0); end
    endtask

    task automatic test_reset_in_wait;
        int e, rh, a0;
        logic [15:0] rd;
        bit ok;
        bus_if.op   = 2'b00;
        bus_if.addr = 9'h040;
        bus_if.req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_if.req = 1'b0;
        #1;
        checks++; if (bus_if.rdata !== 16'h0) begin failures++; $display("FAIL rstw_rdata got=%h exp=0000", bus_if.rdata); end
        checks++; if (s_addr_0 !== 9'h0 || s_read_0 !== 1'b0 || s_write_0 !== 1'b0 || s_din_0 !== 16'h0 || bus_if.ack !== 1'b0) begin
            failures++;
            $display("FAIL rstw_outputs got=addr %h rd %b wr %b din %h ack %b exp=all zero", s_addr_0, s_read_0, s_write_0, s_din_0, bus_if.ack);
        end
        a0 = n_ack;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (n_ack !== a0) begin failures++; $display("FAIL rstw_no_ack got=%0d exp=%0d", n_ack, a0); end
        do_txn(2'b00, 9'h040, 16'h0000, 0, e, rd, rh, ok);
        checks++; if (e !== 5) begin failures++; $display("FAIL rstw_next_latency got=%0d exp=5", e); end
        checks++; if (rd !== 16'h01F3) begin failures++; $display("FAIL rstw_next_data got=%h exp=01f3", rd); end
    endtask

    initial begin
        rst          = 1'b1;
        s_ready_0    = 1'b1;
        bus_if.req   = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        test_reset();
        test_write_read();
        test_stall();
        test_set();
        test_clear();
        test_back_to_back();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_ep_status_bus.md
Name: usb_ep_status_bus

Overview:
- Bus-side front end driving the aux R/W port of the EP status store (9-bit halfword address, 16-bit data, 3-cycle read latency, `s_ready_0` arbitration).
- Converts single-beat CSR bus transactions into aux port accesses: read, write, bit-set and bit-clear. Set and clear are implemented as read-modify-write.
- Holds one transaction at a time and returns a single-cycle `bus_ack`.
- Sits between the CPU-side CSR decoder and the EP status store.

Parameters:
- READ_LAT, 3: edges from aux accept edge to `s_dout_3` valid, counting the accept edge. Fixed by the status store pipeline.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- bus_addr  in  9  EP status halfword address
- bus_wdata  in  16  write data, or bit mask for set/clear
- bus_op  in  2  00 read, 01 write, 10 set bits (OR), 11 clear bits (AND NOT)
- bus_req  in  1  request strobe; held with `bus_addr`/`bus_op`/`bus_wdata` stable until `bus_ack`
- bus_ack  out  1  single-cycle completion
- bus_rdata  out  16  read data, valid with `bus_ack`; for set/clear, the pre-modify value
- s_addr_0  out  9  aux port address
- s_read_0  out  1  aux read request
- s_write_0  out  1  aux write request
- s_din_0  out  16  aux write data
- s_dout_3  in  16  aux read data
- s_ready_0  in  1  aux request accepted this cycle

Behaviour:
- Reset (async), all registered:
  - `bus_ack`=0, `bus_rdata`=0, `s_read_0`=0, `s_write_0`=0, `s_addr_0`=0, `s_din_0`=0.
  - FSM=IDLE, latency counter=0.
- Accept rule:
  - An aux request is accepted on a rising edge where the request is high and `s_ready_0`=1.
  - While not accepted, the request and `s_addr_0`/`s_din_0` are held unchanged.
  - Requests are deasserted in the cycle after acceptance.
- FSM states:
  - IDLE: on `bus_req`=1 and `bus_ack`=0, latch addr/op/wdata. Op 01 -> WR, assert `s_write_0`, `s_din_0`=wdata. Other ops -> RD, assert `s_read_0`.
  - WR: hold until accepted, then -> ACK.
  - RD: hold until accepted, load counter=READ_LAT-1, then -> WAIT.
  - WAIT: decrement counter each cycle. At counter 0, `s_dout_3` is valid; capture it into the data register.
    - Op 00 -> ACK.
    - Op 10: `s_din_0` = data | mask, assert `s_write_0` -> WB.
    - Op 11: `s_din_0` = data & ~mask, assert `s_write_0` -> WB.
  - WB: hold until accepted, then -> ACK.
  - ACK: `bus_ack`=1 for exactly one cycle; `bus_rdata` = captured data (reads and set/clear) or unchanged (writes). Then -> IDLE.
- Latency with `s_ready_0` always 1, counting from the edge that samples `bus_req` to the cycle `bus_ack` is high:
  - write: 2 edges
  - read: 2+READ_LAT edges
  - set/clear: 3+READ_LAT edges
- `bus_req` still high in the ACK cycle is not a new request. A new request is sampled only in IDLE, at the earliest the cycle after the ack.
- Set/clear is NOT atomic against priority-port writes landing between the read and the write-back; software/ucode must avoid that overlap.
- `s_ready_0` low for any number of cycles stalls only WR/RD/WB. The WAIT counter runs only after acceptance.
- A `bus_op` or `bus_addr` change during a transaction is ignored; latched values are used.
- Reset mid-transaction: everything returns to IDLE immediately with no ack. A read in flight in the status store is discarded.

Test Plan:
- Write then read: op 01 addr 0x012 wdata 0xA5C3, ready=1 -> `s_write_0` one cycle with `s_addr_0`=0x012, `s_din_0`=0xA5C3, ack 2 edges after req. Op 00 same addr -> `bus_rdata`=0xA5C3, ack 5 edges after req.
- Stall: read with `s_ready_0`=0 for 4 cycles -> `s_read_0`/`s_addr_0` held stable for 4 cycles, exactly one accepted read, ack at 5+4 edges.
- Set: location holds 0x00F0, op 10 mask 0x0103 -> write-back `s_din_0`=0x01F3, `bus_rdata`=0x00F0, next read returns 0x01F3.
- Clear: location holds 0xFFFF, op 11 mask 0x8001 -> write-back 0x7FFE, `bus_rdata`=0xFFFF.
- Back-to-back: `bus_req` held high across two reads -> exactly one ack per transaction, no duplicate aux access in the ACK cycle.
- Reset in WAIT: assert `rst` mid read -> all outputs 0 that cycle, no ack, next transaction completes normally.
